// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the
// instruction-fetch and data ports; one access per two cycles, ack one cycle after issue.
module mem_port_arbiter #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_load,
    input  logic              d_store,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;

    state_t state;
    logic   last_d;
    logic   d_req;
    logic   grant_d;
    logic   issue;

    // Byte-offset and above-memory address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[XLEN-1:ADDR_W+2], if_addr[1:0],
                                d_addr[XLEN-1:ADDR_W+2], d_addr[1:0]};

    always_comb begin
        d_req     = d_load | d_store;
        grant_d   = d_req & (~if_req | ~last_d);
        issue     = (state == IDLE) & ~reset & (if_req | d_req);

        mem_en    = issue;
        mem_we    = issue & grant_d & d_store;
        mem_addr  = '0;
        if (issue)
            mem_addr = grant_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        mem_wdata = mem_we ? d_wdata : '0;

        // Acks come straight from the WAIT state, masked so a reset aborts them.
        if_ack    = (state == IF_WAIT) & ~reset;
        d_ack     = (state == D_WAIT) & ~reset;
        if_rdata  = if_ack ? mem_rdata : '0;
        d_rdata   = d_ack ? mem_rdata : '0;
        if_stall  = if_req & ~if_ack;
        d_stall   = d_req & ~d_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state  <= grant_d ? D_WAIT : IF_WAIT;
                        last_d <= grant_d;
                    end
                end
                IF_WAIT: state <= IDLE;
                D_WAIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// requesters checked against a transaction-level model and reference memory.
module tb_mem_port_arbiter;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              if_req;
    logic [XLEN-1:0]   if_addr;
    logic [XLEN-1:0]   if_rdata;
    logic              if_ack;
    logic              if_stall;
    logic              d_load;
    logic              d_store;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN-1:0]   d_rdata;
    logic              d_ack;
    logic              d_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    always #5 clock = ~clock;

    mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_stall(if_stall),
        .d_load(d_load), .d_store(d_store), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Power-on SRAM contents: deterministic pattern per word address.
    function automatic logic [31:0] pat(input int unsigned a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // SRAM environment model: read-first, one-cycle read latency.
    logic [31:0] sram [DEPTH];
    bit          sram_wr [DEPTH];
    logic [31:0] sram_rd;
    always @(posedge clock) begin
        if (mem_en) begin
            sram_rd <= sram_wr[mem_addr] ? sram[mem_addr] : pat(int'(mem_addr));
            if (mem_we) begin
                sram[mem_addr]    <= mem_wdata;
                sram_wr[mem_addr] <= 1'b1;
            end
        end
    end
    assign mem_rdata = sram_rd;

    // Reference: expected memory contents plus one outstanding access.
    logic [31:0] refmem [int];
    int          tests = 0;
    int          fails = 0;
    bit          m_busy, m_who_d, m_store, m_last_d;
    logic [31:0] m_rd;
    bit          e_if_ack, e_d_ack;
    int          n_if_acks, n_d_acks;

    function automatic logic [31:0] ref_rd(input int a);
        return refmem.exists(a) ? refmem[a] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ifr, input logic [31:0] ia,
                        input logic dl, input logic ds,
                        input logic [31:0] da, input logic [31:0] dw);
        logic [31:0] e_if_rd, e_d_rd, e_addr, e_wd, a;
        bit          e_en, e_we, g, chk_drd;
        @(negedge clock);
        reset = rst; if_req = ifr; if_addr = ia;
        d_load = dl; d_store = ds; d_addr = da; d_wdata = dw;
        #1;
        e_if_ack = 0; e_d_ack = 0; e_if_rd = '0; e_d_rd = '0;
        e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; chk_drd = 1;
        if (rst) begin
            m_busy = 0; m_last_d = 0;
        end else if (m_busy) begin
            if (m_who_d) begin
                e_d_ack = 1; e_d_rd = m_rd; chk_drd = !m_store;
            end else begin
                e_if_ack = 1; e_if_rd = m_rd;
            end
            m_busy = 0;
        end else if (ifr || dl || ds) begin
            g      = (dl || ds) && (!ifr || !m_last_d);
            a      = g ? da : ia;
            e_en   = 1;
            e_we   = g && ds;
            e_addr = 32'(a[15:2]);
            e_wd   = e_we ? dw : '0;
            m_rd   = ref_rd(int'(e_addr));
            if (e_we) refmem[int'(e_addr)] = dw;
            m_store = e_we; m_who_d = g; m_last_d = g; m_busy = 1;
        end
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("if_ack", 32'(if_ack), 32'(e_if_ack));
        chk("d_ack", 32'(d_ack), 32'(e_d_ack));
        chk("if_stall", 32'(if_stall), 32'(ifr & ~e_if_ack));
        chk("d_stall", 32'(d_stall), 32'((dl | ds) & ~e_d_ack));
        chk("if_rdata", if_rdata, e_if_rd);
        if (chk_drd) chk("d_rdata", d_rdata, e_d_rd);
        if (e_en) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
        end
        if (if_ack) n_if_acks++;
        if (d_ack) n_d_acks++;
    endtask

    task automatic idle(input logic rst);
        step(rst, 0, '0, 0, 0, '0, '0);
    endtask

    bit          f_act, d_act, d_ld, d_st;
    logic [31:0] f_a, d_a, d_w;

    function automatic logic [31:0] rnd_addr();
        return ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2)
             | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        reset = 1; if_req = 0; if_addr = '0; d_load = 0; d_store = 0;
        d_addr = '0; d_wdata = '0;

        // Reset held with no traffic.
        repeat (3) idle(1);
        idle(0);

        // Single fetch at 0x10 -> word 4, ack next cycle.
        step(0, 1, 32'h10, 0, 0, '0, '0);
        chk("fetch_addr4", 32'(mem_addr), 32'd4);
        step(0, 1, 32'h10, 0, 0, '0, '0);
        chk("fetch_rdata", if_rdata, pat(4));
        idle(0);

        // Store then load at 0x20.
        step(0, 0, '0, 0, 1, 32'h20, 32'hDEAD_BEEF);
        chk("store_addr8", 32'(mem_addr), 32'd8);
        step(0, 0, '0, 0, 1, 32'h20, 32'hDEAD_BEEF);
        step(0, 0, '0, 1, 0, 32'h20, '0);
        step(0, 0, '0, 1, 0, 32'h20, '0);
        chk("load_back", d_rdata, 32'hDEAD_BEEF);

        // Contention right after reset: D,F,D,F.
        idle(1);
        n_if_acks = 0; n_d_acks = 0;
        repeat (8) step(0, 1, 32'h44, 1, 0, 32'h20, '0);
        chk("alt_if_acks", 32'(n_if_acks), 32'd2);
        chk("alt_d_acks", 32'(n_d_acks), 32'd2);
        idle(0);

        // Reset in IF_WAIT aborts the ack; store during reset must not issue.
        step(0, 1, 32'h30, 0, 0, '0, '0);
        step(1, 0, '0, 0, 1, 32'h40, 32'h1234_5678);
        idle(0);
        chk("rst_store_dropped", 32'(sram_wr[16]), 32'd0);

        // Withdrawn fetch still acks.
        step(0, 1, 32'h50, 0, 0, '0, '0);
        step(0, 0, '0, 0, 0, '0, '0);

        // Address wrap and load+store treated as store.
        step(0, 1, 32'h0001_0004, 0, 0, '0, '0);
        chk("wrap_addr1", 32'(mem_addr), 32'd1);
        step(0, 1, 32'h0001_0004, 0, 0, '0, '0);
        step(0, 0, '0, 1, 1, 32'h0002_0060, 32'hCAFE_F00D);
        chk("ld_st_we", 32'(mem_we), 32'd1);
        step(0, 0, '0, 1, 1, 32'h0002_0060, 32'hCAFE_F00D);
        step(0, 0, '0, 1, 0, 32'h60, '0);
        step(0, 0, '0, 1, 0, 32'h60, '0);
        chk("ld_st_back", d_rdata, 32'hCAFE_F00D);

        // Randomized requesters obeying hold-until-ack.
        f_act = 0; d_act = 0;
        for (int i = 0; i < 600; i++) begin
            if (e_if_ack) f_act = 0;
            if (e_d_ack)  d_act = 0;
            if (!f_act && $urandom_range(0, 2) == 0) begin
                f_act = 1; f_a = rnd_addr();
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_a = rnd_addr(); d_w = $urandom;
                d_st = $urandom_range(0, 1) == 1; d_ld = !d_st;
            end
            step(i % 97 == 96, f_act, f_a, d_act & d_ld, d_act & d_st, d_a, d_w);
            if (i % 97 == 96) begin
                f_act = 0; d_act = 0; e_if_ack = 0; e_d_ack = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
